// File: rtl/wall_raster_gen.sv
// ----------------------------------------------------------------------------
// wall_raster_gen
//
// Tile-map wall raster generator for the VGA path of the ball game. A writable
// map holds one N_LAYERS-bit entry per (1<<TILE_SHIFT)-square tile of the
// active area. The current line/pixel from the sync generator are looked up
// through a fixed three-register pipeline (address, map read, gated output),
// so BitRaster shows the pixel sampled two edges earlier. Sticky per-layer
// collision flags record every cycle where the ball overlaps a wall bit.
//
// After reset the block sweeps the whole map once (busy high) to load the
// default contents, then accepts tile writes every cycle.
//
// Optional feature macro: WALL_BORDER_EN
//   defined   : initial map has layer 0 set on every edge tile (closed wall)
//   undefined : initial map is all zeros
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset; restarts map initialisation
//   line       current scan line
//   pixel      current pixel within the line
//   BitRaster  per-layer wall bit for the pixel sampled two edges earlier
//   wr_valid   tile write request
//   wr_ready   high when writes are accepted (after initialisation)
//   wr_row     tile row of the write
//   wr_col     tile column of the write
//   wr_data    layer bits stored in the tile
//   wr_err     one-cycle pulse after an accepted out-of-range write
//   busy       map initialisation in progress
//   ball_px    ball covers the pixel currently shown on BitRaster
//   hit        sticky per-layer collision flags
//   hit_clr    clear all hit flags (a simultaneous new hit still sets)
// ----------------------------------------------------------------------------
module wall_raster_gen #(
   parameter int H_RES      = 640,
   parameter int V_RES      = 480,
   parameter int TILE_SHIFT = 4,
   parameter int N_LAYERS   = 2,
   parameter int LINE_W     = 9,
   parameter int PIXEL_W    = 10
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [LINE_W-1:0]            line,
   input  logic [PIXEL_W-1:0]           pixel,
   output logic [N_LAYERS-1:0]          BitRaster,
   input  logic                         wr_valid,
   output logic                         wr_ready,
   input  logic [LINE_W-TILE_SHIFT-1:0] wr_row,
   input  logic [PIXEL_W-TILE_SHIFT-1:0] wr_col,
   input  logic [N_LAYERS-1:0]          wr_data,
   output logic                         wr_err,
   output logic                         busy,
   input  logic                         ball_px,
   output logic [N_LAYERS-1:0]          hit,
   input  logic                         hit_clr
);

   localparam int COLS  = H_RES >> TILE_SHIFT;
   localparam int ROWS  = V_RES >> TILE_SHIFT;
   localparam int DEPTH = ROWS * COLS;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int RW    = LINE_W - TILE_SHIFT;
   localparam int CW    = PIXEL_W - TILE_SHIFT;

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   state_t state, state_next;

   // Row-major tile index; callers guarantee row < ROWS and col < COLS.
   function automatic logic [AW-1:0] tile_addr(input logic [RW-1:0] r,
                                                input logic [CW-1:0] c);
      return AW'(int'(r) * COLS + int'(c));
   endfunction

   // -------------------------------------------------------------------------
   // Control FSM
   // -------------------------------------------------------------------------
   logic [AW-1:0] ptr;
   logic          ptr_last;

   assign ptr_last = (ptr == AW'(DEPTH - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples values from before the edge, independent of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= INIT;
      else     state <= state_next;
   end

   // NOTE: every combinational output gets a default first, so no path
   // through the case can leave a signal unassigned and infer a latch.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      wr_ready   = 1'b0;
      unique case (state)
         INIT: begin
            busy = 1'b1;
            if (ptr_last) state_next = RUN;
         end
         RUN: begin
            wr_ready = 1'b1;
         end
         default: state_next = INIT;
      endcase
   end

   // Clear pointer. INIT is only re-entered through reset, which also zeroes
   // the pointer, so no wrap handling is needed when leaving INIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                ptr <= '0;
      else if (state == INIT) ptr <= ptr + AW'(1);
   end

   // -------------------------------------------------------------------------
   // Default tile contents written during INIT
   // -------------------------------------------------------------------------
   logic [N_LAYERS-1:0] init_data;

`ifdef WALL_BORDER_EN
   // Row/column shadow counters track ptr so the border test needs no divider.
   logic [RW-1:0] init_row;
   logic [CW-1:0] init_col;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         init_row <= '0;
         init_col <= '0;
      end else if (state == INIT) begin
         if (init_col == CW'(COLS - 1)) begin
            init_col <= '0;
            init_row <= init_row + RW'(1);
         end else begin
            init_col <= init_col + CW'(1);
         end
      end
   end

   always_comb begin
      init_data = '0;
      if ((init_row == '0) || (init_row == RW'(ROWS - 1)) ||
          (init_col == '0) || (init_col == CW'(COLS - 1)))
         init_data = N_LAYERS'(1);
   end
`else
   assign init_data = '0;
`endif

   // -------------------------------------------------------------------------
   // Map write port: INIT sweep or accepted in-range tile write
   // -------------------------------------------------------------------------
   logic                wr_fire;
   logic                wr_in_range;
   logic                mem_we;
   logic [AW-1:0]       mem_waddr;
   logic [N_LAYERS-1:0] mem_wdata;

   assign wr_fire     = wr_valid & wr_ready;
   assign wr_in_range = (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = ptr;
      mem_wdata = init_data;
      if (state == INIT) begin
         mem_we = 1'b1;
      end else if (wr_fire && wr_in_range) begin
         mem_we    = 1'b1;
         mem_waddr = tile_addr(wr_row, wr_col);
         mem_wdata = wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wr_err <= 1'b0;
      else     wr_err <= wr_fire & ~wr_in_range;
   end

   // -------------------------------------------------------------------------
   // Lookup pipeline
   //   edge N   : s1_addr / s1_inr  <- line, pixel
   //   edge N+1 : rd_data / s2_inr  <- map[s1_addr] (read-first vs. writes)
   //   edge N+2 : BitRaster         <- rd_data gated by in-range and RUN
   // -------------------------------------------------------------------------
   logic                pix_in_range;
   logic [AW-1:0]       s1_addr;
   logic                s1_inr;
   logic                s2_inr;
   logic [N_LAYERS-1:0] rd_data;
   logic [N_LAYERS-1:0] mem [DEPTH];

   assign pix_in_range = (int'(pixel) < H_RES) && (int'(line) < V_RES);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_addr <= '0;
         s1_inr  <= 1'b0;
         s2_inr  <= 1'b0;
      end else begin
         s1_inr  <= pix_in_range;
         // Clamp so an off-screen pixel never indexes past the map.
         s1_addr <= pix_in_range
                    ? tile_addr(line[LINE_W-1:TILE_SHIFT], pixel[PIXEL_W-1:TILE_SHIFT])
                    : '0;
         s2_inr  <= s1_inr;
      end
   end

   // NOTE: the map and its read register have no reset; INIT rewrites every
   // entry, and the output stage masks rd_data until the map is valid.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      rd_data <= mem[s1_addr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             BitRaster <= '0;
      else if ((state == RUN) && s2_inr)   BitRaster <= rd_data;
      else                                 BitRaster <= '0;
   end

   // -------------------------------------------------------------------------
   // Sticky collision flags; a new hit overrides a simultaneous clear.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         hit <= '0;
      else if (state == RUN)
         hit <= (hit & ~{N_LAYERS{hit_clr}}) | (BitRaster & {N_LAYERS{ball_px}});
   end

endmodule

// File: doc/wall_raster_gen.md
# wall_raster_gen

Tile-map wall raster generator for the ball game's VGA path. Supersedes the fixed-pattern wall generator with a writable tile map of configurable tile size, resolution and layer count (outer walls, inner walls, more). Takes the current `line`/`pixel` from the sync generator and returns one raster bit per layer two cycles later. Latches sticky per-layer ball/wall collision flags for the game logic.

## Interface
Parameters:
- `H_RES`, 640, active pixels per line; multiple of `1<<TILE_SHIFT`
- `V_RES`, 480, active lines; multiple of `1<<TILE_SHIFT`
- `TILE_SHIFT`, 4, log2 of tile edge in pixels (16×16 tiles)
- `N_LAYERS`, 2, raster layers; bit 0 = outer walls, bit 1 = inner walls
- `LINE_W`, 9, width of `line`
- `PIXEL_W`, 10, width of `pixel`

Derived: `COLS = H_RES>>TILE_SHIFT`, `ROWS = V_RES>>TILE_SHIFT`, `DEPTH = ROWS*COLS`.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `line`  in  LINE_W  current scan line
- `pixel`  in  PIXEL_W  current pixel in line
- `BitRaster`  out  N_LAYERS  per-layer wall bit for the pixel sampled 2 cycles earlier
- `wr_valid`  in  1  tile write request
- `wr_ready`  out  1  write accepted when `wr_valid & wr_ready`
- `wr_row`  in  LINE_W-TILE_SHIFT  tile row
- `wr_col`  in  PIXEL_W-TILE_SHIFT  tile column
- `wr_data`  in  N_LAYERS  layer bits for the tile
- `wr_err`  out  1  one-cycle pulse: accepted write was out of range
- `busy`  out  1  map initialisation in progress
- `ball_px`  in  1  ball covers the pixel currently on `BitRaster`
- `hit`  out  N_LAYERS  sticky collision flags
- `hit_clr`  in  1  clear all `hit` bits

## Operation
- FSM states: INIT, RUN.
- Reset enters INIT with clear pointer 0. Every output resets to 0, except `busy`, which resets to 1.
- INIT:
  - Writes one entry per cycle at address `ptr`, `ptr` runs 0..DEPTH-1.
  - Default value per entry is set by the Configuration section.
  - Then transitions to RUN. INIT lasts exactly DEPTH cycles.
  - During INIT: `busy`=1, `wr_ready`=0, `BitRaster`=0, `hit` does not update.
- RUN:
  - `busy`=0, `wr_ready`=1 every cycle.
  - An accepted write to address `wr_row*COLS + wr_col` stores `wr_data`.
  - An accepted write with `wr_row>=ROWS` or `wr_col>=COLS` is ignored and pulses `wr_err` on the next cycle.
- Lookup pipeline:
  - S1 registers the tile address plus an in-range flag (`pixel<H_RES && line<V_RES`).
  - S2 registers the map read ANDed with in-range.
  - Out-of-range pixels give `BitRaster`=0.
- A read and a write to the same address in the same cycle: the read returns the old data.
- Collision:
  - Each cycle, `hit[k]` is set when `ball_px & BitRaster[k]`.
  - `hit_clr` clears all bits.
  - Set and clear in the same cycle: set wins.
- `rst` asserted mid-INIT or mid-RUN restarts INIT. Map contents are rewritten; pipeline and `hit` are cleared.

## Timing
- `line`/`pixel` sampled at edge N produce `BitRaster` at edge N+2. Latency is fixed, including across writes.
- Write accepted at edge N affects lookups sampled at edge N+1 or later.
- `wr_err` is high for exactly the cycle after the offending accept.
- `busy` falls on the edge DEPTH cycles after reset release; `wr_ready` rises on that same edge.
- `hit` updates one edge after the `ball_px`/`BitRaster` coincidence.

## Configuration
- `WALL_BORDER_EN` defined: INIT writes layer 0 = 1 in every tile with row 0, row ROWS-1, col 0 or col COLS-1. All other bits are 0, giving a closed outer wall after reset.
- `WALL_BORDER_EN` undefined: INIT writes all zeros; the map is blank until written.

## Test plan
- Reset, default parameters, `WALL_BORDER_EN` defined -> `busy` high for 1200 cycles, then low. Then `line`=0, `pixel`=5 gives `BitRaster`=2'b01 two cycles later; `line`=100, `pixel`=100 gives 2'b00.
- RUN, write row 3, col 4, data 2'b10 -> sample `line`=50, `pixel`=70 -> `BitRaster`=2'b10 at +2. Same-cycle read of that tile during the write returns 2'b00.
- Write `wr_row`=30, `wr_col`=0 -> `wr_err` pulses for 1 cycle; map unchanged.
- `pixel`=640 or `line`=480 -> `BitRaster`=0 regardless of map contents.
- `ball_px`=1 while `BitRaster`=2'b01 -> `hit`=2'b01 next cycle. Then `hit_clr`=1 in the same cycle as a new coincidence on layer 1 -> `hit`=2'b10.
- Assert `rst` mid-RUN after writes -> all outputs 0, `busy`=1, INIT repeats. Written tiles return to defaults.
